// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the execute stage and a byte-wide
// data memory. A request is accepted only in IDLE; stores spend one cycle
// driving the memory write strobe, loads hold mem_read for READ_LAT cycles,
// capture the returned byte and present it to write-back until it is taken.
//
// Handshakes: a transfer happens at a rising clock edge where valid and
// ready are both 1. The producer keeps valid and its payload stable until
// that edge; ready never depends combinationally on valid. req_* is the
// request channel (this block is the consumer) and rsp_* is the response
// channel (this block is the producer).
//
// READ_LAT must lie in 1..3; the read counter is two bits wide.
module mem_access_ctrl #(
  parameter int READ_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_base,
  input  logic [7:0] req_imm,
  input  logic [7:0] req_wdata,
  input  logic [2:0] req_rd,
  output logic [7:0] mem_address,
  output logic [7:0] mem_write_data,
  output logic       mem_write,
  output logic       mem_read,
  input  logic [7:0] mem_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_rd,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value seen during the final READ cycle.
  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  state_t     state;
  state_t     next_state;
  logic [1:0] read_cnt;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [2:0] tag_q;
  logic [7:0] rsp_data_q;
  logic [2:0] rsp_rd_q;
  logic       req_fire;
  logic       read_done;

  // Ready is gated by reset so nothing looks acceptable while held in reset.
  assign req_ready = (state == IDLE) && reset;
  assign req_fire  = req_valid && req_ready;
  assign read_done = (state == READ) && (read_cnt == LAST_CNT);

  // State register; reset aborts any in-flight store or load immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: store takes one WRITE cycle, load goes READ then RESP.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          next_state = req_write ? WRITE : READ;
        end
      end
      WRITE: next_state = IDLE;
      READ: begin
        if (read_done) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Read-cycle counter: zero outside READ, counts cycles spent in READ.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_cnt <= '0;
    end else if (state == READ) begin
      read_cnt <= read_cnt + 2'd1;
    end else begin
      read_cnt <= '0;
    end
  end

  // Request capture; the effective address wraps modulo 256.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
    end else if (req_fire) begin
      addr_q  <= req_base + req_imm;
      wdata_q <= req_wdata;
      tag_q   <= req_rd;
    end
  end

  // Response capture at the edge closing the last READ cycle; held through RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
    end else if (read_done) begin
      rsp_data_q <= mem_data;
      rsp_rd_q   <= tag_q;
    end
  end

  // Strobes decode directly from state, so they are mutually exclusive.
  assign mem_write      = (state == WRITE);
  assign mem_read       = (state == READ);
  assign rsp_valid      = (state == RESP);
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_rd         = rsp_rd_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a READ_LAT=1 instance carries most of the
// traffic, a READ_LAT=3 instance is exercised by its own scenario. A bench
// memory answers the DUT; a separate reference memory, updated from the
// issued stores, predicts every load.
module tb_mem_access_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_base  = '0;
  logic [7:0] req_imm   = '0;
  logic [7:0] req_wdata = '0;
  logic [2:0] req_rd    = '0;
  logic       rsp_ready = 1'b0;
  logic       req_ready;
  logic [7:0] mem_address, mem_write_data, mem_data, rsp_data;
  logic       mem_write, mem_read, rsp_valid;
  logic [2:0] rsp_rd;
  logic [1:0] dbg_state;

  logic       req_valid3 = 1'b0;
  logic       rsp_ready3 = 1'b0;
  logic       req_ready3;
  logic [7:0] mem_address3, mem_write_data3, mem_data3, rsp_data3;
  logic       mem_write3, mem_read3, rsp_valid3;
  logic [2:0] rsp_rd3;
  logic [1:0] dbg_state3;

  mem_access_ctrl #(.READ_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data(mem_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .dbg_state(dbg_state)
  );

  mem_access_ctrl #(.READ_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write),
    .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_address(mem_address3), .mem_write_data(mem_write_data3),
    .mem_write(mem_write3), .mem_read(mem_read3), .mem_data(mem_data3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_rd(rsp_rd3),
    .dbg_state(dbg_state3)
  );

  // ---------------- memories and scoreboard ----------------
  logic [7:0]  tb_mem  [256];
  logic [7:0]  ref_mem [256];
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  assign mem_data  = tb_mem[mem_address];
  assign mem_data3 = tb_mem[mem_address3];

  always @(posedge clock) begin
    if (mem_write) tb_mem[mem_address] <= mem_write_data;
  end

  // Read and write strobes must never overlap.
  always @(negedge clock) begin
    if (reset) begin
      n_checks++;
      if ((mem_write && mem_read) !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_exclusive: mem_write=%b mem_read=%b expected not both 1",
                 mem_write, mem_read);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a request and returns #1 after the handshake edge.
  task automatic send_req(input logic w, input logic [7:0] b, input logic [7:0] i,
                          input logic [7:0] d, input logic [2:0] rd);
    int waited;
    waited = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_base = b; req_imm = i;
    req_wdata = d; req_rd = rd;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_accept_timeout: req_ready=%b expected 1 within 20 cycles", req_ready);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // Waits for rsp_valid after a load handshake; reports edges and READ cycles.
  task automatic wait_rsp(output int lat, output int rd_cycles);
    lat = 0;
    rd_cycles = 0;
    while (!rsp_valid && lat < 20) begin
      if (mem_read) rd_cycles++;
      @(posedge clock);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b expected 1 within 20 cycles", rsp_valid);
    end
  endtask

  task automatic accept_rsp();
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({req_ready, mem_write, mem_read, rsp_valid, mem_address, mem_write_data,
         rsp_data, rsp_rd} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b %b %b %b %h %h %h %h expected all zero",
               req_ready, mem_write, mem_read, rsp_valid, mem_address, mem_write_data,
               rsp_data, rsp_rd);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_store();
    ref_mem[8'h01] = 8'h05;
    send_req(1'b1, 8'h00, 8'h01, 8'h05, 3'd0);
    n_checks++;
    if ({mem_write, mem_read, rsp_valid, req_ready, mem_address, mem_write_data} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h05}) begin
      n_fail++;
      $display("FAIL store_cycle: wr=%b rd=%b rv=%b rdy=%b addr=%h data=%h expected 1 0 0 0 01 05",
               mem_write, mem_read, rsp_valid, req_ready, mem_address, mem_write_data);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if ({mem_write, rsp_valid, req_ready, mem_address, mem_write_data} !==
        {1'b0, 1'b0, 1'b1, 8'h01, 8'h05}) begin
      n_fail++;
      $display("FAIL store_after: wr=%b rv=%b rdy=%b addr=%h data=%h expected 0 0 1 01 05",
               mem_write, rsp_valid, req_ready, mem_address, mem_write_data);
    end
  endtask

  task automatic test_load();
    int lat, rdc;
    logic [2:0] tag;
    tag = 3'($urandom_range(1, 7));
    send_req(1'b0, 8'h00, 8'h01, 8'($urandom), tag);
    wait_rsp(lat, rdc);
    n_checks++;
    if (lat !== 1 || rdc !== 1) begin
      n_fail++;
      $display("FAIL load_latency: edges=%0d read_cycles=%0d expected 1 1", lat, rdc);
    end
    n_checks++;
    if ({rsp_data, rsp_rd} !== {ref_mem[8'h01], tag}) begin
      n_fail++;
      $display("FAIL load_data: data=%h rd=%0d expected %h %0d", rsp_data, rsp_rd,
               ref_mem[8'h01], tag);
    end
    accept_rsp();
    n_checks++;
    if ({rsp_valid, req_ready, mem_read} !== 3'b010) begin
      n_fail++;
      $display("FAIL load_release: rv=%b rdy=%b rd=%b expected 0 1 0",
               rsp_valid, req_ready, mem_read);
    end
  endtask

  task automatic test_wrap();
    int lat, rdc;
    logic [7:0] d;
    d = 8'($urandom);
    ref_mem[8'h01] = d;
    send_req(1'b1, 8'hFE, 8'h03, d, 3'd0);
    n_checks++;
    if ({mem_write, mem_address, mem_write_data} !== {1'b1, 8'h01, d}) begin
      n_fail++;
      $display("FAIL wrap_store: wr=%b addr=%h data=%h expected 1 01 %h",
               mem_write, mem_address, mem_write_data, d);
    end
    @(posedge clock);
    #1;
    send_req(1'b0, 8'h80, 8'h81, 8'h00, 3'd6);
    n_checks++;
    if ({mem_read, mem_address} !== {1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL wrap_load_addr: rd=%b addr=%h expected 1 01", mem_read, mem_address);
    end
    wait_rsp(lat, rdc);
    n_checks++;
    if ({rsp_data, rsp_rd} !== {d, 3'd6}) begin
      n_fail++;
      $display("FAIL wrap_load_data: data=%h rd=%0d expected %h 6", rsp_data, rsp_rd, d);
    end
    accept_rsp();
  endtask

  task automatic test_backpressure();
    int lat, rdc;
    logic [7:0] a, exp_d, probe_a;
    logic [2:0] tag;
    a = 8'($urandom_range(16, 127));
    probe_a = 8'($urandom_range(128, 255));
    exp_d = ref_mem[a];
    tag = 3'($urandom_range(0, 7));
    send_req(1'b0, a, 8'h00, 8'h00, tag);
    wait_rsp(lat, rdc);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_base = probe_a; req_imm = 8'h00;
    req_wdata = ~ref_mem[probe_a]; req_rd = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if ({rsp_valid, req_ready, mem_write, rsp_data, rsp_rd} !==
          {1'b1, 1'b0, 1'b0, exp_d, tag}) begin
        n_fail++;
        $display("FAIL backpressure_hold: rv=%b rdy=%b wr=%b data=%h rd=%0d expected 1 0 0 %h %0d",
                 rsp_valid, req_ready, mem_write, rsp_data, rsp_rd, exp_d, tag);
      end
    end
    @(negedge clock);
    req_valid = 1'b0;
    accept_rsp();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (tb_mem[probe_a] !== ref_mem[probe_a]) begin
      n_fail++;
      $display("FAIL backpressure_ignored_req: mem[%h]=%h expected %h",
               probe_a, tb_mem[probe_a], ref_mem[probe_a]);
    end
  endtask

  task automatic test_reset_mid_read();
    send_req(1'b0, 8'($urandom_range(1, 255)), 8'h00, 8'h00, 3'd5);
    n_checks++;
    if (mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL midread_in_read: mem_read=%b expected 1", mem_read);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, mem_write, mem_read, rsp_valid, mem_address, mem_write_data,
         rsp_data, rsp_rd} !== 30'd0) begin
      n_fail++;
      $display("FAIL midread_reset_outputs: got %b %b %b %b %h %h %h %h expected all zero",
               req_ready, mem_write, mem_read, rsp_valid, mem_address, mem_write_data,
               rsp_data, rsp_rd);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midread_release_ready: req_ready=%b expected 1", req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if ({rsp_valid, mem_read, mem_write} !== 3'b000) begin
        n_fail++;
        $display("FAIL midread_no_response: rv=%b rd=%b wr=%b expected 0 0 0",
                 rsp_valid, mem_read, mem_write);
      end
    end
  endtask

  task automatic test_random();
    int lat, rdc, hold;
    logic w;
    logic [7:0] b, i, d, a;
    logic [2:0] tag;
    logic [10:0] got, exp;
    int diffs;
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      b = 8'($urandom); i = 8'($urandom); d = 8'($urandom);
      tag = 3'($urandom_range(0, 7));
      a = 8'((32'(b) + 32'(i)) % 256);
      if (w) begin
        ref_mem[a] = d;
        send_req(1'b1, b, i, d, tag);
        n_checks++;
        if ({mem_write, mem_read, rsp_valid, mem_address, mem_write_data} !==
            {1'b1, 1'b0, 1'b0, a, d}) begin
          n_fail++;
          $display("FAIL random_store: wr=%b rd=%b rv=%b addr=%h data=%h expected 1 0 0 %h %h",
                   mem_write, mem_read, rsp_valid, mem_address, mem_write_data, a, d);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if ({mem_write, req_ready} !== 2'b01) begin
          n_fail++;
          $display("FAIL random_store_done: wr=%b rdy=%b expected 0 1", mem_write, req_ready);
        end
      end else begin
        exp_q.push_back({tag, ref_mem[a]});
        send_req(1'b0, b, i, d, tag);
        wait_rsp(lat, rdc);
        n_checks++;
        if (lat !== 1 || rdc !== 1) begin
          n_fail++;
          $display("FAIL random_load_latency: edges=%0d read_cycles=%0d expected 1 1", lat, rdc);
        end
        got = {rsp_rd, rsp_data};
        hold = $urandom_range(0, 3);
        for (int k = 0; k < hold; k++) begin
          @(posedge clock);
          #1;
          n_checks++;
          if ({rsp_valid, rsp_rd, rsp_data} !== {1'b1, got}) begin
            n_fail++;
            $display("FAIL random_load_stable: rv=%b rd/data=%h expected 1 %h",
                     rsp_valid, {rsp_rd, rsp_data}, got);
          end
        end
        accept_rsp();
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random_load_data: rd/data=%h expected %h", got, exp);
        end
      end
    end
    diffs = 0;
    for (int k = 0; k < 256; k++) begin
      if (tb_mem[k] !== ref_mem[k]) diffs++;
    end
    n_checks++;
    if (diffs !== 0) begin
      n_fail++;
      $display("FAIL memory_image: %0d differing bytes expected 0", diffs);
    end
  endtask

  task automatic test_lat3();
    int lat, rdc;
    logic [7:0] b, i, a;
    logic [2:0] tag;
    b = 8'($urandom); i = 8'($urandom);
    a = 8'((32'(b) + 32'(i)) % 256);
    tag = 3'($urandom_range(0, 7));
    @(negedge clock);
    n_checks++;
    if (req_ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL lat3_idle: req_ready3=%b expected 1", req_ready3);
    end
    req_valid3 = 1'b1; req_write = 1'b0; req_base = b; req_imm = i; req_rd = tag;
    @(posedge clock);
    #1;
    req_valid3 = 1'b0;
    lat = 0;
    rdc = 0;
    while (!rsp_valid3 && lat < 20) begin
      if (mem_read3) rdc++;
      @(posedge clock);
      #1;
      lat++;
    end
    n_checks++;
    if (lat !== 3 || rdc !== 3) begin
      n_fail++;
      $display("FAIL lat3_latency: edges=%0d read_cycles=%0d expected 3 3", lat, rdc);
    end
    n_checks++;
    if ({rsp_valid3, rsp_data3, rsp_rd3, mem_write3} !== {1'b1, ref_mem[a], tag, 1'b0}) begin
      n_fail++;
      $display("FAIL lat3_data: rv=%b data=%h rd=%0d wr=%b expected 1 %h %0d 0",
               rsp_valid3, rsp_data3, rsp_rd3, mem_write3, ref_mem[a], tag);
    end
    @(negedge clock);
    rsp_ready3 = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready3 = 1'b0;
    n_checks++;
    if ({rsp_valid3, req_ready3} !== 2'b01) begin
      n_fail++;
      $display("FAIL lat3_release: rv=%b rdy=%b expected 0 1", rsp_valid3, req_ready3);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 256; k++) begin
      tb_mem[k]  = 8'($urandom);
      ref_mem[k] = tb_mem[k];
    end
    test_reset();
    test_store();
    test_load();
    test_wrap();
    test_backpressure();
    test_reset_mid_read();
    test_random();
    test_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
